if_prefetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined CPU. It issues sequential fetches to instruction memory and buffers {PC, instruction} pairs in a small queue. It presents the head entry to the IF stage as `IF_inst` / `IF_TruePC`, holds it while the pipeline stalls, and flushes on branch/jump redirect. It replaces the hand-driven `IF_inst` stimulus path, adding look-ahead buffering and redirect handling.

---
 rtl/ifq_pkg.sv | 16 +
 rtl/ifq_fifo.sv | 67 ++++++
 rtl/if_prefetch_queue.sv | 132 +++++++++++++
 tb/tb_if_prefetch_queue.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction-fetch prefetch queue.
//   ifq_state_e  - fetch FSM state (FETCH / WAIT / DROP)
//   IFQ_NOP      - instruction presented when the queue head is empty
//   IFQ_PC_STEP  - sequential PC increment
package ifq_pkg;

    typedef enum logic [1:0] {
        IFQ_FETCH = 2'd0,
        IFQ_WAIT  = 2'd1,
        IFQ_DROP  = 2'd2
    } ifq_state_e;

    localparam logic [31:0] IFQ_NOP     = 32'h0000_0000;
    localparam int unsigned IFQ_PC_STEP = 4;

endpackage

// File: rtl/ifq_fifo.sv
// ifq_fifo: ring-buffer queue with read/write pointers, occupancy count,
// push/pop and a synchronous flush that empties the queue.
//   clk, rst   - clock, asynchronous active-high reset
//   push_i     - write wdata_i at the tail (ignored when full or flushing)
//   pop_i      - advance the head (ignored when empty or flushing)
//   flush_i    - empty the queue on this edge; overrides push and pop
//   rdata_o    - head entry (contents undefined when empty_o)
//   empty_o    - no entries held
//   full_o     - DEPTH entries held
module ifq_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign rdata_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an empty queue is never read as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end. Issues sequential fetches
// (one outstanding at most), buffers {PC, instruction} pairs and presents the
// head to the IF stage; flushes on branch/jump redirect.
//   clk, rst                - clock, asynchronous active-high reset
//   imem_req/imem_addr      - fetch request (accepted in the cycle asserted)
//   imem_ack/imem_data      - return for the outstanding request
//   stall                   - hold the head entry
//   redirect/redirect_pc    - flush queue and restart fetching at redirect_pc
//   IF_valid/IF_inst        - head valid / head instruction (NOP when empty)
//   IF_TruePC/IF_TrueNextPC - head PC (0 when empty) and PC + 4
//   perf_flushes/perf_starve- saturating event counters
// Build option: define IFQ_PERF_EN to generate the performance counters;
// otherwise both perf outputs are tied to zero.
//
// state | meaning
// FETCH | request next word when a queue slot is free
// WAIT  | request in flight, data will be pushed
// DROP  | request in flight after a redirect, data will be discarded
module if_prefetch_queue
    import ifq_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              IF_valid,
    output logic [DATA_W-1:0] IF_inst,
    output logic [ADDR_W-1:0] IF_TruePC,
    output logic [ADDR_W-1:0] IF_TrueNextPC,
    output logic [15:0]       perf_flushes,
    output logic [15:0]       perf_starve
);

    ifq_state_e               state_q;
    logic [ADDR_W-1:0]        fetch_pc_q;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [ADDR_W+DATA_W-1:0] fifo_head;

    // A request is only made with a free slot, so the returning word always fits.
    assign imem_req  = !rst && !redirect && (state_q == IFQ_FETCH) && !fifo_full;
    assign imem_addr = fetch_pc_q;

    assign fifo_push = (state_q == IFQ_WAIT) && imem_ack && !redirect;
    assign fifo_pop  = IF_valid && !stall && !redirect;

    ifq_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect),
        .wdata_i ({fetch_pc_q, imem_data}),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign IF_valid      = !fifo_empty;
    assign IF_inst       = IF_valid ? fifo_head[DATA_W-1:0] : DATA_W'(IFQ_NOP);
    assign IF_TruePC     = IF_valid ? fifo_head[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign IF_TrueNextPC = IF_TruePC + ADDR_W'(IFQ_PC_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IFQ_FETCH;
            fetch_pc_q <= RESET_PC;
        end else if (redirect) begin
            fetch_pc_q <= redirect_pc;
            // An ack in the redirect cycle completes the in-flight request
            // (its data is discarded), so there is nothing left to drop.
            if (state_q == IFQ_FETCH || imem_ack) state_q <= IFQ_FETCH;
            else                                  state_q <= IFQ_DROP;
        end else begin
            unique case (state_q)
                IFQ_FETCH: if (imem_req) state_q <= IFQ_WAIT;
                IFQ_WAIT: begin
                    if (imem_ack) begin
                        fetch_pc_q <= fetch_pc_q + ADDR_W'(IFQ_PC_STEP);
                        state_q    <= IFQ_FETCH;
                    end
                end
                IFQ_DROP: if (imem_ack) state_q <= IFQ_FETCH;
                default:  state_q <= IFQ_FETCH;
            endcase
        end
    end

`ifdef IFQ_PERF_EN
    logic [15:0] flushes_q, flushes_d;
    logic [15:0] starve_q, starve_d;

    always_comb begin
        flushes_d = flushes_q;
        starve_d  = starve_q;
        if (redirect && flushes_q != 16'hFFFF)                flushes_d = flushes_q + 16'd1;
        if (!IF_valid && !stall && starve_q != 16'hFFFF)      starve_d  = starve_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flushes_q <= '0;
            starve_q  <= '0;
        end else begin
            flushes_q <= flushes_d;
            starve_q  <= starve_d;
        end
    end

    assign perf_flushes = flushes_q;
    assign perf_starve  = starve_q;
`else
    assign perf_flushes = '0;
    assign perf_starve  = '0;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        IF_valid;
    logic [31:0] IF_inst;
    logic [31:0] IF_TruePC;
    logic [31:0] IF_TrueNextPC;
    logic [15:0] perf_flushes;
    logic [15:0] perf_starve;

    always #5 clk = ~clk;

    if_prefetch_queue #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .IF_valid      (IF_valid),
        .IF_inst       (IF_inst),
        .IF_TruePC     (IF_TruePC),
        .IF_TrueNextPC (IF_TrueNextPC),
        .perf_flushes  (perf_flushes),
        .perf_starve   (perf_starve)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Memory returns a word tagged by its address; nonzero for every PC.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    // Reference: after reset or a redirect to X, the IF stage consumes
    // X, X+4, X+8, ... (mod 2^32) in order.
    logic [31:0] exp_q[$];

    function automatic void reload(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(i * 4));
    endfunction

    // Instruction memory model
    bit          mem_pend = 0;
    logic [31:0] mem_addr = '0;
    int          mem_lat = 0;
    int          mem_fixed_lat = 1;
    bit          stray_now = 0;

    task automatic cycle(input bit r, input bit st, input bit rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        if (r && !rst) reload(RESET_PC);
        rst         = r;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        if (rd && !r) reload(rpc);
        imem_ack  = 1'b0;
        imem_data = '0;
        if (mem_pend) begin
            if (mem_lat <= 1) begin
                imem_ack  = 1'b1;
                imem_data = inst_of(mem_addr);
                mem_pend  = 0;
            end else begin
                mem_lat--;
            end
        end else if (stray_now) begin
            imem_ack  = 1'b1;
            imem_data = 32'hDEAD_BEEF;
        end
        stray_now = 0;
        #1;
        if (!rst) begin
            if (rd) check("req_masked_on_redirect", {31'b0, imem_req}, 32'd0);
            if (imem_req) begin
                check("single_outstanding", {31'b0, mem_pend}, 32'd0);
                mem_pend = 1;
                mem_addr = imem_addr;
                mem_lat  = (mem_fixed_lat > 0) ? mem_fixed_lat : int'($urandom_range(1, 4));
            end
        end
    endtask

    // Monitor
    bit          prev_hold = 0;
    logic [31:0] prev_inst, prev_pc;
    int          exp_flush = 0;
    int          exp_starve = 0;

    function automatic logic [31:0] sat16(input int v);
`ifdef IFQ_PERF_EN
        return (v > 65535) ? 32'hFFFF : 32'(v);
`else
        return (v < 0) ? 32'hFFFF : 32'h0;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_hold  = 0;
            exp_flush  = 0;
            exp_starve = 0;
        end else begin
            check("perf_flushes", {16'b0, perf_flushes}, sat16(exp_flush));
            check("perf_starve", {16'b0, perf_starve}, sat16(exp_starve));
            if (redirect) exp_flush++;
            if (!IF_valid && !stall) exp_starve++;

            if (!IF_valid) check("nop_when_empty", IF_inst, 32'h0);
            if (prev_hold) begin
                check("stall_valid", {31'b0, IF_valid}, 32'd1);
                check("stall_inst", IF_inst, prev_inst);
                check("stall_pc", IF_TruePC, prev_pc);
            end
            prev_hold = IF_valid && stall && !redirect;
            prev_inst = IF_inst;
            prev_pc   = IF_TruePC;

            if (IF_valid && !stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL scoreboard_empty: got pc %h, expected no entry", IF_TruePC);
                end else begin
                    logic [31:0] pc;
                    pc = exp_q.pop_front();
                    check("head_pc", IF_TruePC, pc);
                    check("head_inst", IF_inst, inst_of(pc));
                    check("head_next_pc", IF_TrueNextPC, pc + 32'd4);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  first;
        bit  found;
        logic [31:0] rpc;

        reload(RESET_PC);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, IF_valid}, 32'd0);
        check("rst_inst", IF_inst, 32'h0);
        check("rst_pc", IF_TruePC, 32'h0);
        check("rst_next_pc", IF_TrueNextPC, 32'h4);
        check("rst_perf_flushes", {16'b0, perf_flushes}, 32'h0);
        check("rst_perf_starve", {16'b0, perf_starve}, 32'h0);

        // First fetch latency with a 1-cycle memory
        mem_fixed_lat = 1;
        first = 0;
        for (int c = 1; c <= 10; c++) begin
            cycle(0, 0, 0, '0);
            if (IF_valid) begin first = c; break; end
        end
        check("first_valid_cycle", 32'(first), 32'd3);
        check("first_pc", IF_TruePC, RESET_PC);
        check("first_inst", IF_inst, inst_of(RESET_PC));
        check("first_next_pc", IF_TrueNextPC, RESET_PC + 32'd4);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0);

        // Long stall fills the queue; a stray ack while full is ignored
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, '0);
        check("req_off_when_full", {31'b0, imem_req}, 32'd0);
        check("valid_while_stalled", {31'b0, IF_valid}, 32'd1);
        stray_now = 1;
        cycle(0, 1, 0, '0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, '0);

        // Redirect while a request is in flight; its ack arrives 2 cycles later
        mem_fixed_lat = 3;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, '0);
            if (mem_pend && mem_lat == 3) begin found = 1; break; end
        end
        check("wait_redirect_setup", {31'b0, found}, 32'd1);
        cycle(0, 0, 1, 32'h40);
        first = 0;
        for (int c = 1; c <= 20; c++) begin
            cycle(0, 0, 0, '0);
            if (IF_valid) begin first = c; break; end
        end
        check("redirect_first_pc", IF_TruePC, 32'h40);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, '0);

        // Redirect coinciding with push and pop
        mem_fixed_lat = 1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 0, '0);
            if (mem_pend && mem_lat <= 1 && IF_valid) begin found = 1; break; end
        end
        check("pushpop_setup", {31'b0, found}, 32'd1);
        cycle(0, 0, 1, 32'h100);
        cycle(0, 0, 0, '0);
        check("pushpop_flush_valid", {31'b0, IF_valid}, 32'd0);
        check("pushpop_flush_inst", IF_inst, 32'h0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, '0);

        // PC wrap
        cycle(0, 0, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 14; i++) cycle(0, 0, 0, '0);

        // Reset mid-request, then exactly three redirects
        found = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, '0);
            if (mem_pend) begin found = 1; break; end
        end
        check("midrst_setup", {31'b0, found}, 32'd1);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, '0);
        check("midrst_valid", {31'b0, IF_valid}, 32'd0);
        check("midrst_perf", {16'b0, perf_flushes}, 32'h0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, '0);
        cycle(0, 0, 1, 32'h200);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0);
        cycle(0, 1, 1, 32'h300);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0);
        cycle(0, 0, 1, 32'h400);
        cycle(0, 0, 0, '0);
`ifdef IFQ_PERF_EN
        check("perf_three_flushes", {16'b0, perf_flushes}, 32'd3);
`else
        check("perf_three_flushes", {16'b0, perf_flushes}, 32'd0);
`endif
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, '0);

        // Randomized traffic
        mem_fixed_lat = 0;
        for (int i = 0; i < 2500; i++) begin
            bit st, rd;
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 19) == 0);
            rpc = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
            cycle(0, st, rd, rpc);
        end
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
